// File: rtl/menu_mode_controller_if.sv
// Front-panel / PicoBlaze signal bundle for menu_mode_controller.
// The controller uses the slave modport. The driving side (top-level decode) uses the master modport.
interface menu_mode_controller_if #(
    parameter int IDX_W = 3
);
    logic [4:0]       btn_raw;       // {pause_play, back, select, scroll_down, scroll_up}
    logic             host_wr;
    logic [7:0]       host_wdata;
    logic             host_rd_ack;
    logic [IDX_W-1:0] item_idx;
    logic [1:0]       mode;
    logic             event_pending;
    logic             run_start;
    logic             run_stop;

    modport master (
        output btn_raw, host_wr, host_wdata, host_rd_ack,
        input  item_idx, mode, event_pending, run_start, run_stop
    );

    modport slave (
        input  btn_raw, host_wr, host_wdata, host_rd_ack,
        output item_idx, mode, event_pending, run_start, run_stop
    );
endinterface

// File: rtl/menu_mode_controller.sv
// Menu/mode controller: button debounce, menu FSM and PicoBlaze command/status.
// The optional macro CONFIRM_TIMEOUT_EN adds an auto-abort timer for the CONFIRM state.
// Without the macro, CONFIRM waits for select/back/host indefinitely.
module menu_mode_controller #(
    parameter int                 N_ITEMS         = 6,
    parameter int                 IDX_W           = 3,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter int                 CNT_W           = 20,
    parameter logic [N_ITEMS-1:0] CONFIRM_MASK    = 6'b001100,
    parameter int                 TIMEOUT_CYCLES  = 500000000
) (
    input logic                   clk,
    input logic                   reset,   // synchronous, active-low
    menu_mode_controller_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_MENU    = 2'd0,
        MODE_CONFIRM = 2'd1,
        MODE_RUN     = 2'd2,
        MODE_PAUSED  = 2'd3
    } mode_e;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_BACK  = 3;
    localparam int BTN_PAUSE = 4;

    localparam logic [1:0]       CMD_DONE     = 2'b00;
    localparam logic [1:0]       CMD_SET_ITEM = 2'b01;
    localparam logic [1:0]       CMD_ABORT    = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_ITEMS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};

    logic [4:0]       sync1_q, sync2_q, db_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [4:0]       press_s, btn_sel_s;
    mode_e            mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ev_q, ev_d, start_q, start_d, stop_q, stop_d;
    logic             change_s, run_or_paused_s, expire_s;
    logic [1:0]       host_cmd_s;
    logic [4:0]       set_val_s;
    logic             unused_s;

    assign host_cmd_s      = bus.host_wdata[1:0];
    assign set_val_s       = bus.host_wdata[6:2];
    assign unused_s        = bus.host_wdata[7];
    assign run_or_paused_s = (mode_q == MODE_RUN) || (mode_q == MODE_PAUSED);

`ifdef CONFIRM_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr_q;

    // CONFIRM dwell timer: held at zero outside CONFIRM so every entry starts fresh
    always_ff @(posedge clk) begin
        if (!reset || (mode_q != MODE_CONFIRM)) begin
            tmr_q <= {TMR_W{1'b0}};
        end else begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    assign expire_s = (mode_q == MODE_CONFIRM) && (tmr_q == TMR_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire_s = 1'b0;
`endif

    // Synchronise raw buttons and debounce: level follows sync only after a stable run
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 5'b0;
            sync2_q <= 5'b0;
            db_q    <= 5'b0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= {CNT_W{1'b0}};
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= {CNT_W{1'b0}};
                    db_q[i]  <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press pulse fires in the cycle the debounced level is about to rise
    always_comb begin
        press_s = 5'b0;
        for (int i = 0; i < 5; i++) begin
            press_s[i] = sync2_q[i] & ~db_q[i] & (cnt_q[i] == CNT_LAST);
        end
    end

    // Keep only the highest-priority press: back > select > pause_play > up > down
    always_comb begin
        btn_sel_s = 5'b0;
        if (press_s[BTN_BACK]) begin
            btn_sel_s[BTN_BACK] = 1'b1;
        end else if (press_s[BTN_SEL]) begin
            btn_sel_s[BTN_SEL] = 1'b1;
        end else if (press_s[BTN_PAUSE]) begin
            btn_sel_s[BTN_PAUSE] = 1'b1;
        end else if (press_s[BTN_UP]) begin
            btn_sel_s[BTN_UP] = 1'b1;
        end else if (press_s[BTN_DOWN]) begin
            btn_sel_s[BTN_DOWN] = 1'b1;
        end else begin
            btn_sel_s = 5'b0;
        end
    end

    // Next mode/index/pulses: host strobe wins over buttons, timeout is last resort
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (bus.host_wr) begin
            case (host_cmd_s)
                CMD_DONE: begin
                    if (run_or_paused_s) begin
                        mode_d = MODE_MENU;
                        stop_d = 1'b1;
                    end else begin
                        mode_d = mode_q;
                    end
                end
                CMD_SET_ITEM: begin
                    if ((mode_q == MODE_MENU) && (int'(set_val_s) < N_ITEMS)) begin
                        idx_d = IDX_W'(set_val_s);
                    end else begin
                        idx_d = idx_q;
                    end
                end
                CMD_ABORT: begin
                    mode_d = MODE_MENU;
                    stop_d = run_or_paused_s;
                end
                default: mode_d = mode_q;
            endcase
        end else if (btn_sel_s != 5'b0) begin
            case (mode_q)
                MODE_MENU: begin
                    if (btn_sel_s[BTN_UP]) begin
                        idx_d = (idx_q == IDX_LAST) ? IDX_ZERO : idx_q + IDX_W'(1);
                    end else if (btn_sel_s[BTN_DOWN]) begin
                        idx_d = (idx_q == IDX_ZERO) ? IDX_LAST : idx_q - IDX_W'(1);
                    end else if (btn_sel_s[BTN_SEL]) begin
                        if (CONFIRM_MASK[idx_q]) begin
                            mode_d = MODE_CONFIRM;
                        end else begin
                            mode_d  = MODE_RUN;
                            start_d = 1'b1;
                        end
                    end else begin
                        mode_d = mode_q;
                    end
                end
                MODE_CONFIRM: begin
                    if (btn_sel_s[BTN_SEL]) begin
                        mode_d  = MODE_RUN;
                        start_d = 1'b1;
                    end else if (btn_sel_s[BTN_BACK]) begin
                        mode_d = MODE_MENU;
                    end else begin
                        mode_d = mode_q;
                    end
                end
                MODE_RUN, MODE_PAUSED: begin
                    if (btn_sel_s[BTN_BACK]) begin
                        mode_d = MODE_MENU;
                        stop_d = 1'b1;
                    end else if (btn_sel_s[BTN_PAUSE]) begin
                        mode_d = (mode_q == MODE_RUN) ? MODE_PAUSED : MODE_RUN;
                    end else begin
                        mode_d = mode_q;
                    end
                end
                default: mode_d = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end

        // A select/back on the expiry cycle has already moved mode_d out of CONFIRM
        if (expire_s && !bus.host_wr && (mode_d == MODE_CONFIRM)) begin
            mode_d = MODE_MENU;
        end else begin
            start_d = start_d & ~stop_d;
        end

        change_s = (mode_d != mode_q) || (idx_d != idx_q);
        if (change_s) begin
            ev_d = 1'b1;
        end else if (bus.host_rd_ack) begin
            ev_d = 1'b0;
        end else begin
            ev_d = ev_q;
        end
    end

    // Registered outputs and state
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q  <= MODE_MENU;
            idx_q   <= IDX_ZERO;
            ev_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            ev_q    <= ev_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    assign bus.item_idx      = idx_q;
    assign bus.mode          = mode_q;
    assign bus.event_pending = ev_q;
    assign bus.run_start     = start_q;
    assign bus.run_stop      = stop_q;
endmodule

// File: tb/tb_menu_mode_controller.sv
// Scoreboard bench for menu_mode_controller with DEBOUNCE_CYCLES=4, N_ITEMS=6.
module tb_menu_mode_controller;
    localparam int DC = 4;
    localparam int NI = 6;
    localparam int IW = 3;

    typedef struct {
        int mode;
        int idx;
        int ev;
        int starts;
        int stops;
    } exp_t;

    logic clk;
    logic reset;
    menu_mode_controller_if #(.IDX_W(IW)) bus ();

    menu_mode_controller #(
        .N_ITEMS(NI), .IDX_W(IW), .DEBOUNCE_CYCLES(DC), .CNT_W(20),
        .CONFIRM_MASK(6'b001100), .TIMEOUT_CYCLES(500000000)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t     sb_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       check_req = 0;
    int       check_ack = 0;
    int       start_cnt = 0;
    int       stop_cnt = 0;
    int       m_mode = 0, m_idx = 0, m_ev = 0, m_starts = 0, m_stops = 0;
    bit [5:0] cmask = 6'b001100;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Highest-priority pressed button, -1 if none: back, select, pause, up, down
    function automatic int pick(logic [4:0] mask);
        int order[5] = '{3, 2, 4, 0, 1};
        for (int k = 0; k < 5; k++) if (mask[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic void model_btn(int b);
        case (m_mode)
            0: begin
                if (b == 0) m_idx = (m_idx + 1) % NI;
                else if (b == 1) m_idx = (m_idx + NI - 1) % NI;
                else if (b == 2) begin
                    if (cmask[m_idx]) m_mode = 1;
                    else begin m_mode = 2; m_starts++; end
                end
            end
            1: begin
                if (b == 2) begin m_mode = 2; m_starts++; end
                else if (b == 3) m_mode = 0;
            end
            default: begin
                if (b == 3) begin m_mode = 0; m_stops++; end
                else if (b == 4) m_mode = (m_mode == 2) ? 3 : 2;
            end
        endcase
    endfunction

    function automatic void model_host(logic [7:0] hb);
        int arg = int'(hb[6:2]);
        case (hb[1:0])
            2'b00: if (m_mode >= 2) begin m_mode = 0; m_stops++; end
            2'b01: if (m_mode == 0 && arg < NI) m_idx = arg;
            2'b10: begin if (m_mode >= 2) m_stops++; m_mode = 0; end
            default: ;
        endcase
    endfunction

    function automatic void model_step(int btn, bit hw, logic [7:0] hb, bit ack);
        int om = m_mode;
        int oi = m_idx;
        if (hw) model_host(hb);
        else if (btn >= 0) model_btn(btn);
        if (om != m_mode || oi != m_idx) m_ev = 1;
        else if (ack) m_ev = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_check();
        exp_t e;
        e.mode = m_mode; e.idx = m_idx; e.ev = m_ev; e.starts = m_starts; e.stops = m_stops;
        sb_q.push_back(e);
        m_starts = 0;
        m_stops = 0;
        check_req++;
        repeat (2) tick();
    endtask

    task automatic press(logic [4:0] mask, int hold);
        bus.btn_raw = mask;
        repeat (hold) tick();
        bus.btn_raw = 5'b0;
        repeat (12) tick();
        if (hold >= DC) model_step(pick(mask), 1'b0, 8'h00, 1'b0);
        push_check();
    endtask

    // Strobe host_wr/ack exactly on the cycle the press pulse is accepted
    task automatic press_timed(logic [4:0] mask, bit hw, logic [7:0] hb, bit ack);
        bus.btn_raw = mask;
        repeat (5) tick();
        bus.host_wr = hw; bus.host_wdata = hb; bus.host_rd_ack = ack;
        tick();
        bus.host_wr = 1'b0; bus.host_rd_ack = 1'b0;
        repeat (3) tick();
        bus.btn_raw = 5'b0;
        repeat (12) tick();
        model_step(pick(mask), hw, hb, ack);
        push_check();
    endtask

    task automatic host(logic [7:0] hb);
        bus.host_wr = 1'b1; bus.host_wdata = hb;
        tick();
        bus.host_wr = 1'b0;
        repeat (2) tick();
        model_step(-1, 1'b1, hb, 1'b0);
        push_check();
    endtask

    task automatic ack();
        bus.host_rd_ack = 1'b1;
        tick();
        bus.host_rd_ack = 1'b0;
        model_step(-1, 1'b0, 8'h00, 1'b1);
        push_check();
    endtask

    // Monitor: count pulses, compare against the scoreboard when a check is due
    always @(negedge clk) begin
        exp_t e;
        if (bus.run_start === 1'b1) start_cnt++;
        if (bus.run_stop === 1'b1) stop_cnt++;
        if (bus.run_start === 1'b1 || bus.run_stop === 1'b1)
            chk("start_stop_exclusive", int'(bus.run_start & bus.run_stop), 0);
        if (check_req != check_ack) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk("mode", int'(bus.mode), e.mode);
                chk("item_idx", int'(bus.item_idx), e.idx);
                chk("event_pending", int'(bus.event_pending), e.ev);
                chk("run_start_pulses", start_cnt, e.starts);
                chk("run_stop_pulses", stop_cnt, e.stops);
            end
            start_cnt = 0;
            stop_cnt = 0;
            check_ack++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] mask;
        logic [7:0] hb;
        int         r;
        reset = 1'b0;
        bus.btn_raw = 5'b0; bus.host_wr = 1'b0; bus.host_wdata = 8'h00; bus.host_rd_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        push_check();                                  // reset state

        press(5'b00001, 3);                            // glitch: no pulse
        // held scroll_up: idx changes exactly 6 cycles after the raw edge
        bus.btn_raw = 5'b00001;
        repeat (5) tick();
        chk("latency_before", int'(bus.item_idx), 0);
        tick();
        chk("latency_at", int'(bus.item_idx), 1);
        repeat (4) tick();
        bus.btn_raw = 5'b0;
        repeat (12) tick();
        model_step(0, 1'b0, 8'h00, 1'b0);
        push_check();
        ack();

        host(8'h01);                                   // idx 0
        press(5'b00010, 6);                            // wrap down -> 5
        press(5'b00001, 6);                            // wrap up -> 0

        host(8'h0D);                                   // idx 3
        press(5'b00100, 6);                            // CONFIRM
        press(5'b01000, 6);                            // back -> MENU
        press(5'b00100, 6);
        press(5'b00100, 6);                            // RUN, run_start
        host(8'h02);                                   // ABORT, run_stop

        host(8'h01);
        press(5'b00100, 6);                            // RUN
        press(5'b10000, 6);                            // PAUSED
        press(5'b10000, 6);                            // RUN, no start
        host(8'h00);                                   // DONE

        press(5'b00100, 6);                            // RUN
        press(5'b01100, 6);                            // select+back -> MENU
        host(8'h19);                                   // idx 6 ignored
        host(8'h11);                                   // idx 4
        press_timed(5'b00001, 1'b1, 8'h05, 1'b0);      // SET 1, scroll dropped
        ack();
        press_timed(5'b00001, 1'b0, 8'h00, 1'b1);      // set and ack same cycle

        host(8'h01);
        press(5'b00100, 6);                            // RUN
        bus.btn_raw = 5'b01000;                        // back, mid-debounce
        repeat (4) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.btn_raw = 5'b0;
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_idx", int'(bus.item_idx), 0);
        chk("rst_event", int'(bus.event_pending), 0);
        chk("rst_stop", int'(bus.run_stop), 0);
        repeat (12) tick();
        m_mode = 0; m_idx = 0; m_ev = 0; m_starts = 0; m_stops = 0;
        push_check();

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            mask = 5'b1 << $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) mask = mask | (5'b1 << $urandom_range(0, 4));
            hb = {1'b0, 5'($urandom_range(0, 8)), 2'($urandom_range(0, 3))};
            if (r <= 4) press(mask, $urandom_range(1, 8));
            else if (r <= 6) host(hb);
            else if (r == 7) ack();
            else if (r == 8) press_timed(mask, 1'b1, hb, 1'b0);
            else press_timed(mask, 1'b0, 8'h00, 1'b1);
        end

        repeat (3) tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
